// File: rtl/madd_pkg.sv
// Shared definitions for the pipelined multiply-add unit: mode encodings,
// Booth digit types and parameter limits.
package madd_pkg;

  typedef enum logic [1:0] {
    MADD_U = 2'b00,
    MADD_S = 2'b01,
    MAC_S  = 2'b10,
    MAC_U  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } booth_mag_e;

  typedef struct packed {
    logic       neg;
    booth_mag_e mag;
  } booth_digit_t;

  localparam int W_MIN   = 8;
  localparam int W_MAX   = 64;
  localparam int LAT_MIN = 2;
  localparam int LAT_MAX = 3;

  function automatic logic is_signed(input logic [1:0] mode);
    return (mode == MADD_S) || (mode == MAC_S);
  endfunction

  function automatic logic is_mac(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth row: encodes a multiplier triplet and emits the
// signed partial product (0, +/-A, +/-2A) of the pre-extended multiplicand.
module booth_pp_gen
  import madd_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   triplet,
  input  logic [W:0]   a_ext,
  output logic [W+1:0] row
);

  booth_digit_t digit;
  logic [W+1:0] mag_row;

  always_comb begin
    case (triplet)
      3'b001, 3'b010: digit = '{neg: 1'b0, mag: ONE};
      3'b011:         digit = '{neg: 1'b0, mag: TWO};
      3'b100:         digit = '{neg: 1'b1, mag: TWO};
      3'b101, 3'b110: digit = '{neg: 1'b1, mag: ONE};
      default:        digit = '{neg: 1'b0, mag: ZERO};
    endcase
  end

  always_comb begin
    case (digit.mag)
      ONE:     mag_row = {a_ext[W], a_ext};
      TWO:     mag_row = {a_ext, 1'b0};
      default: mag_row = '0;
    endcase
    row = digit.neg ? -mag_row : mag_row;
  end

endmodule

// File: rtl/madd_pipe.sv
// Pipelined Z = A*B + C / Z = ACC + A*B unit with radix-4 Booth core and
// valid/ready on both sides. Define MADD_PIPE_SAT_EN to clamp on overflow.
module madd_pipe
  import madd_pkg::*;
#(
  parameter int W   = 32,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [1:0]   mode,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         ovf
);

  localparam int PW   = 2 * W + 2;
  localparam int ROWS = W / 2 + 1;

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic         s1_valid;
  logic [W-1:0] s1_a, s1_b, s1_c;
  logic [1:0]   s1_mode;
  logic         s1_clr;

  // Stage 1 captures the operand beat; any stall freezes the whole pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_mode  <= '0;
      s1_clr   <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_c    <= c;
        s1_mode <= mode;
        s1_clr  <= acc_clr;
      end
    end
  end

  logic         s1_sgn;
  logic [W:0]   a_ext;
  logic [W+2:0] b_trip;
  logic [W+1:0] rows [ROWS];
  logic [PW-1:0] prod;

  // Unsigned operands zero-extend, so the extra top row absorbs B's MSB.
  assign s1_sgn = is_signed(s1_mode);
  assign a_ext  = {s1_sgn & s1_a[W-1], s1_a};
  assign b_trip = {{2{s1_sgn & s1_b[W-1]}}, s1_b, 1'b0};

  for (genvar i = 0; i < ROWS; i++) begin : g_pp
    booth_pp_gen #(.W(W)) u_pp (
      .triplet (b_trip[2*i+2:2*i]),
      .a_ext   (a_ext),
      .row     (rows[i])
    );
  end

  always_comb begin
    prod = '0;
    for (int i = 0; i < ROWS; i++) begin
      prod = prod + ({{W{rows[i][W+1]}}, rows[i]} << (2 * i));
    end
  end

  logic          fin_valid;
  logic [PW-1:0] fin_prod;
  logic [W-1:0]  fin_c;
  logic [1:0]    fin_mode;
  logic          fin_clr;

  if (LAT == 3) begin : g_lat3
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fin_valid <= 1'b0;
        fin_prod  <= '0;
        fin_c     <= '0;
        fin_mode  <= '0;
        fin_clr   <= 1'b0;
      end else if (!stall) begin
        fin_valid <= s1_valid;
        if (s1_valid) begin
          fin_prod <= prod;
          fin_c    <= s1_c;
          fin_mode <= s1_mode;
          fin_clr  <= s1_clr;
        end
      end
    end
  end else begin : g_lat2
    assign fin_valid = s1_valid;
    assign fin_prod  = prod;
    assign fin_c     = s1_c;
    assign fin_mode  = s1_mode;
    assign fin_clr   = s1_clr;
  end

  logic [W-1:0]  acc;
  logic          f_sgn;
  logic [PW-1:0] opnd;
  logic [PW-1:0] sum;
  logic          ovf_n;
  logic [W-1:0]  z_n;

  always_comb begin
    f_sgn = is_signed(fin_mode);
    if (is_mac(fin_mode)) begin
      opnd = fin_clr ? '0 : {{(W+2){f_sgn & acc[W-1]}}, acc};
    end else begin
      opnd = {{(W+2){f_sgn & fin_c[W-1]}}, fin_c};
    end
    sum = fin_prod + opnd;
    if (f_sgn) begin
      ovf_n = !((&sum[PW-1:W-1]) || !(|sum[PW-1:W-1]));
    end else begin
      ovf_n = |sum[PW-1:W];
    end
`ifdef MADD_PIPE_SAT_EN
    if (ovf_n && f_sgn) begin
      z_n = sum[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else if (ovf_n) begin
      z_n = sum[PW-1] ? '0 : '1;
    end else begin
      z_n = sum[W-1:0];
    end
`else
    z_n = sum[W-1:0];
`endif
  end

  // ACC is read and written only here, so back-to-back MAC beats chain freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else if (!stall) begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        z   <= z_n;
        ovf <= ovf_n;
        if (is_mac(fin_mode)) begin
          acc <= z_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_madd_pipe.sv
// Scoreboard bench for madd_pipe: a W=32/LAT=3 and a W=8/LAT=2 instance,
// directed vectors with hand-computed results, checked by output monitors.
module tb_madd_pipe;

`ifdef MADD_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] z;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid, in_ready, out_valid, out_ready, acc_clr, ovf;
  logic [31:0] a, b, c, z;
  logic [1:0]  mode;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, acc_clr8, ovf8;
  logic [7:0]  a8, b8, c8, z8;
  logic [1:0]  mode8;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int checks = 0;
  int passes = 0;
  int edges;

  always #5 clk = ~clk;

  madd_pipe #(.W(32), .LAT(3)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .mode(mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .ovf(ovf)
  );

  madd_pipe #(.W(8), .LAT(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .c(c8), .mode(mode8), .acc_clr(acc_clr8),
    .out_valid(out_valid8), .out_ready(out_ready8), .z(z8), .ovf(ovf8)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] ta, tb, tc, input logic [1:0] tm,
                               input logic tclr, input logic [31:0] ez, input logic eovf);
    bit acc_ok = 1'b0;
    int n = 0;
    q32.push_back('{z: ez, ovf: eovf});
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb; c = tc; mode = tm; acc_clr = tclr;
    while (!acc_ok && n < 50) begin
      #4 acc_ok = in_ready;
      @(posedge clk);
      n++;
      if (!acc_ok) @(negedge clk);
    end
    if (!acc_ok) begin
      checks++;
      $display("[TB] FAIL accept32: got no acceptance, expected acceptance within 50 cycles");
    end
  endtask

  task automatic applyStimulus8(input logic [7:0] ta, tb, tc, input logic [1:0] tm,
                                input logic tclr, input logic [7:0] ez, input logic eovf);
    bit acc_ok = 1'b0;
    int n = 0;
    q8.push_back('{z: {24'd0, ez}, ovf: eovf});
    @(negedge clk);
    in_valid8 = 1'b1; a8 = ta; b8 = tb; c8 = tc; mode8 = tm; acc_clr8 = tclr;
    while (!acc_ok && n < 50) begin
      #4 acc_ok = in_ready8;
      @(posedge clk);
      n++;
      if (!acc_ok) @(negedge clk);
    end
    if (!acc_ok) begin
      checks++;
      $display("[TB] FAIL accept8: got no acceptance, expected acceptance within 50 cycles");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_valid8 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: got %0d/%0d beats outstanding, expected 0", q32.size(), q8.size());
      q32.delete();
      q8.delete();
    end
  endtask

  // Monitor for the 32-bit unit: pops on transfer, checks held output on stall.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid) begin
      if (q32.size() == 0) begin
        checks++;
        $display("[TB] FAIL spurious32: got beat z=0x%0h, expected none", z);
      end else if (out_ready) begin
        e32 = q32.pop_front();
        checkOutput("z32", z, e32.z);
        checkOutput("ovf32", ovf, e32.ovf);
      end else begin
        checkOutput("stall_z32", z, q32[0].z);
        checkOutput("stall_in_ready32", in_ready, 0);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        checks++;
        $display("[TB] FAIL spurious8: got beat z=0x%0h, expected none", z8);
      end else begin
        e8 = q8.pop_front();
        checkOutput("z8", z8, e8.z);
        checkOutput("ovf8", ovf8, e8.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] bp_a [11] = '{32'd3, 32'd15, 32'd7, 32'd0, 32'd11, 32'd1, 32'd8, 32'd14,
                             32'h12345678, 32'h00010000, 32'h0000FFFF};
  logic [31:0] bp_b [11] = '{32'd4, 32'd15, 32'd9, 32'd12, 32'd13, 32'd1, 32'd2, 32'd6,
                             32'h00000010, 32'h00010000, 32'h0000FFFF};
  logic [31:0] bp_c [11] = '{32'd10, 32'd255, 32'd1, 32'd200, 32'd5, 32'd0, 32'd17, 32'd99,
                             32'd1, 32'd5, 32'd0};
  logic [31:0] bp_z [11] = '{32'd22, 32'd480, 32'd64, 32'd200, 32'd148, 32'd1, 32'd33, 32'd183,
                             32'h23456781, 32'd5, 32'hFFFE0001};
  logic        bp_o [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; c = '0; mode = 2'b00; acc_clr = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; c8 = '0; mode8 = 2'b00; acc_clr8 = 1'b0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_z", z, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid8", out_valid8, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted while beats are in flight must clear outputs at once.
    applyStimulus(32'd3, 32'd3, 32'd1, 2'b00, 1'b0, 32'd10, 1'b0);
    applyStimulus(32'd2, 32'd8, 32'd0, 2'b00, 1'b0, 32'd16, 1'b0);
    applyStimulus(32'd6, 32'd6, 32'd6, 2'b00, 1'b0, 32'd42, 1'b0);
    idle();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_z", z, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    q32.delete();
    q8.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(32'd5, 32'd7, 32'd3, 2'b00, 1'b0, 32'h26, 1'b0);
    edges = 1;
    while (edges < 10) begin
      #1;
      if (out_valid) break;
      @(negedge clk) in_valid = 1'b0;
      @(posedge clk);
      edges++;
    end
    checkOutput("latency32", edges, 3);
    idle();
    drain();

    applyStimulus(32'hFFFFFFFF, 32'h4, 32'hA, 2'b01, 1'b0, 32'h6, 1'b0);
    applyStimulus(32'h80000000, 32'h80000000, 32'h0, 2'b01, 1'b0, SAT ? 32'h7FFFFFFF : 32'h0, 1'b1);
    applyStimulus(32'h1, 32'h80000000, 32'h0, 2'b01, 1'b0, 32'h80000000, 1'b0);
    applyStimulus(32'h7FFFFFFF, 32'h1, 32'h1, 2'b01, 1'b0, SAT ? 32'h7FFFFFFF : 32'h80000000, 1'b1);
    applyStimulus(32'h80000000, 32'h1, 32'hFFFFFFFF, 2'b01, 1'b0, SAT ? 32'h80000000 : 32'h7FFFFFFF, 1'b1);
    applyStimulus(32'h7FFFFFFF, 32'h2, 32'h0, 2'b01, 1'b0, SAT ? 32'h7FFFFFFF : 32'hFFFFFFFE, 1'b1);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 2'b00, 1'b0, SAT ? 32'hFFFFFFFF : 32'h1, 1'b1);

    // MAC chain with an interleaved MADD that must leave ACC alone.
    applyStimulus(32'd2, 32'd3, 32'hDEAD, 2'b10, 1'b1, 32'd6, 1'b0);
    applyStimulus(32'd1, 32'd1, 32'd100, 2'b00, 1'b0, 32'd101, 1'b0);
    applyStimulus(32'd4, 32'd5, 32'hBEEF, 2'b10, 1'b0, 32'd26, 1'b0);
    applyStimulus(32'd1, 32'd1, 32'd0, 2'b10, 1'b0, 32'd27, 1'b0);
    applyStimulus(32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 32'd27, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'h2, 32'h0, 2'b11, 1'b1, SAT ? 32'hFFFFFFFF : 32'hFFFFFFFE, 1'b1);
    applyStimulus(32'h0, 32'h0, 32'h0, 2'b11, 1'b0, SAT ? 32'hFFFFFFFF : 32'hFFFFFFFE, 1'b0);
    idle();
    drain();

    fork
      begin
        for (int i = 0; i < 11; i++)
          applyStimulus(bp_a[i], bp_b[i], bp_c[i], 2'b00, 1'b0, bp_z[i], bp_o[i]);
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    applyStimulus8(8'hFF, 8'hFF, 8'h00, 2'b11, 1'b1, SAT ? 8'hFF : 8'h01, 1'b1);
    edges = 1;
    while (edges < 10) begin
      #1;
      if (out_valid8) break;
      @(negedge clk) in_valid8 = 1'b0;
      @(posedge clk);
      edges++;
    end
    checkOutput("latency8", edges, 2);
    idle();
    applyStimulus8(8'h00, 8'h00, 8'h00, 2'b11, 1'b0, SAT ? 8'hFF : 8'h01, 1'b0);
    applyStimulus8(8'h80, 8'h80, 8'h00, 2'b01, 1'b0, SAT ? 8'h7F : 8'h00, 1'b1);
    applyStimulus8(8'hFE, 8'h03, 8'h55, 2'b10, 1'b1, 8'hFA, 1'b0);
    applyStimulus8(8'h7F, 8'h7F, 8'h00, 2'b10, 1'b0, SAT ? 8'h7F : 8'hFB, 1'b1);
    idle();
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
